// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared widths, timeout and FSM encoding for mul_arbiter
package mul_arbiter_pkg;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 64;
   localparam int PROD_W  = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1
);

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant0 = req0 & (~req1 | last_grant);
      grant1 = req1 & (~req0 | ~last_grant);
   end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one start/done multiplier between two requesters
module mul_arbiter #(
   parameter int WIDTH   = mul_arbiter_pkg::WIDTH,
   parameter int TIMEOUT = mul_arbiter_pkg::TIMEOUT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     req0_multiplier,
   input  logic [WIDTH-1:0]     req1_multiplier,
   input  logic [WIDTH-1:0]     req0_multiplicand,
   input  logic [WIDTH-1:0]     req1_multiplicand,
   output logic                 ack0,
   output logic                 ack1,
   output logic                 rsp0_valid,
   output logic                 rsp1_valid,
   output logic [2*WIDTH-1:0]   rsp_result,
   output logic                 rsp_error,
   output logic                 busy,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_multiplier,
   output logic [WIDTH-1:0]     mul_multiplicand,
   input  logic [2*WIDTH-1:0]   mul_result,
   input  logic                 mul_done
);

   import mul_arbiter_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state;
   state_t          state_next;
   logic            last_grant;
   logic            owner;
   logic [TW-1:0]   timer;
   logic            timer_expired;
   logic            grant0;
   logic            grant1;
   logic            take_grant;
   logic            finish_ok;
   logic            finish_err;

   rr_arbiter2 u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign timer_expired = (timer == TW'(TIMEOUT - 1));
   assign mul_start     = (state == ISSUE) & mul_done;
   assign busy          = (state != IDLE);

   // A stuck-high done in ISSUE times out exactly like a missing done in WAIT_DONE.
   always_comb begin
      state_next = state;
      take_grant = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      case (state)
         IDLE: begin
            if (grant0 | grant1) begin
               take_grant = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (!mul_done) begin
               state_next = WAIT_DONE;
            end else if (timer_expired) begin
               finish_err = 1'b1;
               state_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (mul_done) begin
               finish_ok  = 1'b1;
               state_next = IDLE;
            end else if (timer_expired) begin
               finish_err = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         owner            <= 1'b0;
         timer            <= '0;
         ack0             <= 1'b0;
         ack1             <= 1'b0;
         rsp0_valid       <= 1'b0;
         rsp1_valid       <= 1'b0;
         rsp_result       <= '0;
         rsp_error        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
      end else begin
         state      <= state_next;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         // Timer restarts on every state change, so ISSUE and WAIT_DONE each get a full budget.
         if (state == IDLE || state_next != state) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
         if (take_grant) begin
            owner            <= grant1;
            last_grant       <= grant1;
            ack0             <= grant0;
            ack1             <= grant1;
            mul_multiplier   <= grant1 ? req1_multiplier : req0_multiplier;
            mul_multiplicand <= grant1 ? req1_multiplicand : req0_multiplicand;
         end
         if (finish_ok | finish_err) begin
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            rsp_error  <= finish_err;
            rsp_result <= finish_ok ? mul_result : '0;
         end
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - scoreboard bench for mul_arbiter with a behavioural multiplier
module tb_mul_arbiter;

   localparam int W = 32;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            req0 = 1'b0;
   logic            req1 = 1'b0;
   logic [W-1:0]    req0_multiplier = '0;
   logic [W-1:0]    req1_multiplier = '0;
   logic [W-1:0]    req0_multiplicand = '0;
   logic [W-1:0]    req1_multiplicand = '0;
   logic            ack0;
   logic            ack1;
   logic            rsp0_valid;
   logic            rsp1_valid;
   logic [2*W-1:0]  rsp_result;
   logic            rsp_error;
   logic            busy;
   logic            mul_start;
   logic [W-1:0]    mul_multiplier;
   logic [W-1:0]    mul_multiplicand;
   logic [2*W-1:0]  mul_result;
   logic            mul_done;

   mul_arbiter #(.WIDTH(W), .TIMEOUT(64)) dut (
      .clock             (clock),
      .reset             (reset),
      .req0              (req0),
      .req1              (req1),
      .req0_multiplier   (req0_multiplier),
      .req1_multiplier   (req1_multiplier),
      .req0_multiplicand (req0_multiplicand),
      .req1_multiplicand (req1_multiplicand),
      .ack0              (ack0),
      .ack1              (ack1),
      .rsp0_valid        (rsp0_valid),
      .rsp1_valid        (rsp1_valid),
      .rsp_result        (rsp_result),
      .rsp_error         (rsp_error),
      .busy              (busy),
      .mul_start         (mul_start),
      .mul_multiplier    (mul_multiplier),
      .mul_multiplicand  (mul_multiplicand),
      .mul_result        (mul_result),
      .mul_done          (mul_done)
   );

   always #5 clock = ~clock;

   // Multiplier model: 0 = real (done back 17 edges after start), 1 = done stuck high, 2 = done never returns.
   int              mode = 0;
   logic            m_busy;
   logic [4:0]      m_cnt;
   logic [W-1:0]    m_a;
   logic [W-1:0]    m_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mul_done   <= 1'b1;
         m_busy     <= 1'b0;
         m_cnt      <= '0;
         m_a        <= '0;
         m_b        <= '0;
         mul_result <= '0;
      end else if (!m_busy) begin
         if (mul_start && mode != 1) begin
            m_a      <= mul_multiplier;
            m_b      <= mul_multiplicand;
            m_busy   <= 1'b1;
            mul_done <= 1'b0;
            m_cnt    <= 5'd16;
         end
      end else if (mode == 0) begin
         if (m_cnt == 5'd0) begin
            mul_done   <= 1'b1;
            m_busy     <= 1'b0;
            mul_result <= 64'(m_a) * 64'(m_b);
         end else begin
            m_cnt <= m_cnt - 5'd1;
         end
      end
   end

   typedef struct {
      bit           port;
      logic [63:0]  result;
      bit           error;
      int           cyc;
   } rsp_t;

   typedef struct {
      bit port;
      int cyc;
   } ack_t;

   rsp_t  rsp_q[$];
   ack_t  ack_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    ack_seen = 0;
   bit    auto_drop = 1'b1;
   int    t0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_op(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int ack_c, input int rsp_c, input bit err);
      ack_t ae;
      rsp_t re;
      ae.port = port;
      ae.cyc  = ack_c;
      ack_q.push_back(ae);
      re.port   = port;
      re.result = err ? 64'd0 : 64'(a) * 64'(b);
      re.error  = err;
      re.cyc    = rsp_c;
      rsp_q.push_back(re);
   endtask

   task automatic tick();
      ack_t a;
      rsp_t r;
      logic bad;
      @(negedge clock);
      cyc++;
      if (ack0 | ack1 | rsp0_valid | rsp1_valid) begin
         bad = ((ack0 | ack1) & (rsp0_valid | rsp1_valid)) | (ack0 & ack1) | (rsp0_valid & rsp1_valid);
         check("handshake_overlap", 64'(bad), 64'd0);
      end
      if (ack0 | ack1) begin
         if (ack_q.size() == 0) begin
            check("unexpected_ack", 64'({ack1, ack0}), 64'd0);
         end else begin
            a = ack_q.pop_front();
            check("ack_port", 64'(ack1), 64'(a.port));
            check("ack_cycle", 64'(cyc), 64'(a.cyc));
            check("busy_at_ack", 64'(busy), 64'd1);
         end
         ack_seen++;
         if (auto_drop && ack0) req0 = 1'b0;
         if (auto_drop && ack1) req1 = 1'b0;
      end
      if (rsp0_valid | rsp1_valid) begin
         if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
         end else begin
            r = rsp_q.pop_front();
            check("rsp_port", 64'(rsp1_valid), 64'(r.port));
            check("rsp_result", rsp_result, r.result);
            check("rsp_error", 64'(rsp_error), 64'(r.error));
            check("rsp_cycle", 64'(cyc), 64'(r.cyc));
            check("busy_at_rsp", 64'(busy), 64'd0);
         end
      end
   endtask

   task automatic drain(input string tag, input int max);
      for (int i = 0; i < max && (ack_q.size() != 0 || rsp_q.size() != 0); i++) tick();
      check(tag, 64'(ack_q.size() + rsp_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_acks"}, 64'({ack1, ack0}), 64'd0);
      check({tag, "_rsps"}, 64'({rsp1_valid, rsp0_valid, rsp_error}), 64'd0);
      check({tag, "_result"}, rsp_result, 64'd0);
      check({tag, "_busy_start"}, 64'({busy, mul_start}), 64'd0);
      check({tag, "_operands"}, {mul_multiplier, mul_multiplicand}, 64'd0);
   endtask

   initial begin
      #100000;
      $fatal(1, "FAIL global_timeout: observed still running expected finished");
   end

   initial begin
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (2) tick();

      // req0 alone, 35 x 17
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd35; req0_multiplicand = 32'd17;
      expect_op(1'b0, 32'd35, 32'd17, t0 + 1, t0 + 20, 1'b0);
      drain("drain_single", 40);

      // Simultaneous requests after reset: req0 first
      pulse_reset();
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd3;     req0_multiplicand = 32'd11;
      req1 = 1'b1; req1_multiplier = 32'd31415; req1_multiplicand = 32'd113;
      expect_op(1'b0, 32'd3, 32'd11, t0 + 1, t0 + 20, 1'b0);
      expect_op(1'b1, 32'd31415, 32'd113, t0 + 21, t0 + 40, 1'b0);
      drain("drain_tie", 60);

      // Both held for four operations: grants alternate
      auto_drop = 1'b0;
      ack_seen = 0;
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd1234;       req0_multiplicand = 32'd5678;
      req1 = 1'b1; req1_multiplier = 32'hFFFF_FFFF;  req1_multiplicand = 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) expect_op(1'b0, 32'd1234, 32'd5678, t0 + 1 + 20 * k, t0 + 20 + 20 * k, 1'b0);
         else            expect_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0 + 1 + 20 * k, t0 + 20 + 20 * k, 1'b0);
      end
      for (int i = 0; i < 100 && ack_seen < 4; i++) tick();
      req0 = 1'b0;
      req1 = 1'b0;
      auto_drop = 1'b1;
      drain("drain_alternate", 40);

      // Done stuck high: timeout from ISSUE
      mode = 1;
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd7; req0_multiplicand = 32'd9;
      expect_op(1'b0, 32'd7, 32'd9, t0 + 1, t0 + 65, 1'b1);
      tick();
      check("stuck_start_early", 64'(mul_start), 64'd1);
      repeat (63) tick();
      check("stuck_start_late", 64'({busy, mul_start}), 64'd3);
      drain("drain_stuck_high", 10);
      check("stuck_start_after", 64'(mul_start), 64'd0);

      // Done never returns: timeout from WAIT_DONE, then normal service
      mode = 2;
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd5; req0_multiplicand = 32'd6;
      expect_op(1'b0, 32'd5, 32'd6, t0 + 1, t0 + 67, 1'b1);
      drain("drain_never_done", 80);
      mode = 0;
      for (int i = 0; i < 40 && !mul_done; i++) tick();
      check("model_recovered", 64'(mul_done), 64'd1);
      t0 = cyc;
      req1 = 1'b1; req1_multiplier = 32'd1; req1_multiplicand = 32'd3;
      expect_op(1'b1, 32'd1, 32'd3, t0 + 1, t0 + 20, 1'b0);
      drain("drain_after_timeout", 40);

      // Asynchronous reset in WAIT_DONE aborts silently
      t0 = cyc;
      req0 = 1'b1; req0_multiplier = 32'd100; req0_multiplicand = 32'd200;
      begin
         ack_t ae;
         ae.port = 1'b0;
         ae.cyc  = t0 + 1;
         ack_q.push_back(ae);
      end
      repeat (10) tick();
      check("busy_before_reset", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      req0 = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (2) tick();
      t0 = cyc;
      req1 = 1'b1; req1_multiplier = 32'd17; req1_multiplicand = 32'd35;
      expect_op(1'b1, 32'd17, 32'd35, t0 + 1, t0 + 20, 1'b0);
      drain("drain_after_reset", 40);
      repeat (25) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one bit-pair multiplier (start/done/result handshake, 2*WIDTH-bit product) between two requesters.
- Arbitrates round-robin and drives the multiplier's start and operand inputs.
- Waits for done, returns the product to the granted requester, and flags a timeout if done never returns.
- Sits between the CPU-side multiply request and the I/O-side multiply request and the single multiplier instance.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- TIMEOUT, 64, maximum cycles in WAIT_DONE before an error response.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  request; hold high with operands stable until the matching ack.
- req0_multiplier, req1_multiplier  in  WIDTH each  multiplier operand.
- req0_multiplicand, req1_multiplicand  in  WIDTH each  multiplicand operand.
- ack0, ack1  out  1 each  one-cycle registered grant/accept pulse.
- rsp0_valid, rsp1_valid  out  1 each  one-cycle registered response pulse.
- rsp_result  out  2*WIDTH  product, valid while any rspN_valid is high.
- rsp_error  out  1  qualifies rspN_valid; 1 = timeout, rsp_result = 0.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  to multiplier start.
- mul_multiplier, mul_multiplicand  out  WIDTH each  latched operands to the multiplier.
- mul_result  in  2*WIDTH  from the multiplier.
- mul_done  in  1  from the multiplier.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, last_grant=1, all outputs 0, latched operands 0, timer 0.
- Reset mid-operation aborts the operation with no response. The integrator drives the multiplier's active-high reset from the same source, inverted.
- IDLE:
  - Tie-break: if both reqs are high, grant the requester not equal to last_grant. If only one is high, grant it.
  - On grant: latch that requester's operands, set last_grant, pulse its ackN next cycle, go to ISSUE.
  - With no req high, stay in IDLE.
- ISSUE:
  - mul_start = (state==ISSUE) & mul_done; this is combinational, so start drops as soon as the multiplier reports busy.
  - When mul_done==0, go to WAIT_DONE and clear the timer.
- WAIT_DONE:
  - Timer increments each cycle.
  - On mul_done==1: register rsp_result=mul_result, rsp_error=0, pulse rspN_valid for the granted N, go to IDLE.
  - If timer reaches TIMEOUT-1 with mul_done still 0: rsp_result=0, rsp_error=1, pulse rspN_valid, go to IDLE.
  - Timeout is sticky-free: the next request is handled normally.
- The ISSUE state also counts toward TIMEOUT (stuck-high done): same error response.
- Latency with a real multiplier (done rises 17 edges after it samples start when WIDTH=32): req sampled in cycle 0, ack in cycle 1, rspN_valid in cycle 20, i.e. WIDTH/2+4 cycles. IDLE is re-entered in cycle 20, so the next grant can be evaluated that cycle.
- Requests are not sampled outside IDLE. A req held high after ack counts as a new request. A req dropped before grant is simply not granted.
- ack and rsp never fire in the same cycle. Only one of ack0/ack1 and one of rsp0_valid/rsp1_valid is high at a time.
- The arbiter passes the product through unmodified; it does no signedness handling.

Decomposition:
- Shared package holds WIDTH, TIMEOUT, the state encodings IDLE/ISSUE/WAIT_DONE, and the product-width constant.
- Sub-module rr_arbiter2: combinational two-way round-robin grant from req0, req1, last_grant, returning grant0/grant1. Everything else stays in mul_arbiter.
- The multiplier is instantiated by the parent, not inside mul_arbiter.

Test Plan:
- req0 alone with 35 x 17, real multiplier → ack0 in cycle 1; rsp0_valid in cycle 20 with rsp_result=595, rsp_error=0; busy low from cycle 20.
- req0 and req1 high together after reset (3 x 11, 31415 x 113) → req0 served first with 33; then req1 acked in cycle 21 with result 3549895; rsp1_valid in cycle 40.
- Both reqs held continuously for 4 operations → grants alternate 0,1,0,1; no ack or rsp overlap.
- Stub multiplier that never drops mul_done → mul_start held; after TIMEOUT=64 cycles, rsp0_valid=1, rsp_error=1, rsp_result=0, state back to IDLE.
- Stub multiplier that drops done but never raises it → error response 64 cycles after entering the wait; a subsequent req1 with the real multiplier (1 x 3) returns 3 normally.
- reset pulsed low during WAIT_DONE → all outputs 0 immediately (asynchronous); no rsp pulse; after release, req1 (17 x 35) returns 595 in 20 cycles.
